data_mem_split: RTL

//  Parametrised byte-addressable data memory for the pipelined core; second generation of the data memory.
//  - Organised as 4 byte-lane banks.
//  - Registered (1-cycle) read data.
//  - Supports misaligned half/word accesses, split into two beats by an FSM that stalls the MEM stage.
//  - Keeps the AddressingControl encoding for lb/lh/lw/lbu/lhu and sb/sh/sw.

---
 rtl/dmem_pkg.sv | 64 ++++++
 rtl/data_mem_split_if.sv | 16 +
 rtl/dmem_bank.sv | 27 ++
 rtl/data_mem_split.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the banked data memory: access-size decode,
// per-beat lane masks, byte-lane rotation and load extension.
package dmem_pkg;

    typedef enum logic [1:0] {MODE_B, MODE_H, MODE_W, MODE_NONE} dmem_mode_t;
    typedef enum logic {S_IDLE, S_SECOND} dmem_state_t;

    function automatic logic [2:0] mode_bytes(input dmem_mode_t mode);
        case (mode)
            MODE_B:  mode_bytes = 3'd1;
            MODE_H:  mode_bytes = 3'd2;
            MODE_W:  mode_bytes = 3'd4;
            default: mode_bytes = 3'd0;
        endcase
    endfunction

    // beat 0: lanes offset..min(offset+size,4)-1; beat 1: lanes 0..offset+size-5
    function automatic logic [3:0] lane_mask(input logic [1:0] offset,
                                             input logic [2:0] size,
                                             input logic       beat);
        logic [3:0] m;
        logic [3:0] end_lane;
        m        = 4'b0000;
        end_lane = {2'b00, offset} + {1'b0, size};
        for (int k = 0; k < 4; k++) begin
            if (beat)
                m[k] = ((4'(k) + 4'd4) < end_lane);
            else
                m[k] = (4'(k) >= {2'b00, offset}) && (4'(k) < end_lane);
        end
        lane_mask = m;
    endfunction

    // Store path: byte i of the data lands in lane (offset+i) mod 4.
    function automatic logic [31:0] rot_left(input logic [31:0] w, input logic [1:0] o);
        case (o)
            2'd1:    rot_left = {w[23:0], w[31:24]};
            2'd2:    rot_left = {w[15:0], w[31:16]};
            2'd3:    rot_left = {w[7:0],  w[31:8]};
            default: rot_left = w;
        endcase
    endfunction

    // Load path: byte i of the result comes from lane (offset+i) mod 4.
    function automatic logic [31:0] rot_right(input logic [31:0] w, input logic [1:0] o);
        case (o)
            2'd1:    rot_right = {w[7:0],  w[31:8]};
            2'd2:    rot_right = {w[15:0], w[31:16]};
            2'd3:    rot_right = {w[23:0], w[31:24]};
            default: rot_right = w;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw,
                                           input dmem_mode_t  mode,
                                           input logic        zext);
        case (mode)
            MODE_B:  extend = zext ? {24'b0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
            MODE_H:  extend = zext ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_split_if.sv
// MEM-stage access bus between the pipeline (master) and the data memory (slave).
interface data_mem_split_if;
    logic        req;
    logic [31:0] A;
    logic        WE;
    logic [2:0]  AddressingControl;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        rd_valid;
    logic        stall;

    modport master (output req, A, WE, AddressingControl, WD,
                    input  RD, rd_valid, stall);
    modport slave  (input  req, A, WE, AddressingControl, WD,
                    output RD, rd_valid, stall);
endinterface

// File: rtl/dmem_bank.sv
// One byte lane of the data memory: 8-bit wide, word-deep, write enable and
// registered read.
module dmem_bank #(
   parameter int ADDR_WIDTH = 17,
   parameter int LANE       = 0,
   parameter     MEM_INIT   = "",
   parameter int INIT_BASE  = 'h10000
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-3:0] addr,
   input  logic [7:0]            wdata,
   output logic [7:0]            rdata
);
   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);

   logic [7:0] mem [0:WORDS-1];
   logic [7:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata_q <= mem[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_split.sv
// Byte-addressable data memory over four lane banks; misaligned half/word
// accesses are split into two beats by a stall FSM.
//
// state    | meaning
// S_IDLE   | accept a new access; aligned ones finish in one beat
// S_SECOND | perform beat 2 of a misaligned access from captured values
module data_mem_split
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 17,
    parameter     MEM_INIT   = "",
    parameter int INIT_BASE  = 'h10000
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_split_if.slave  bus
);
    localparam int LANES = DATA_WIDTH / 8;
    localparam int WAW   = ADDR_WIDTH - 2;

    dmem_state_t          state_q, state_d;

    dmem_mode_t           req_mode;
    logic                 req_zext;
    logic [1:0]           req_off;
    logic [WAW-1:0]       req_word;
    logic [2:0]           req_bytes;
    logic [3:0]           req_end;
    logic                 req_active;
    logic                 req_split;
    logic                 unused_a_hi;

    logic [1:0]           cap_off_q,  cap_off_d;
    logic [WAW-1:0]       cap_word_q, cap_word_d;
    logic                 cap_we_q,   cap_we_d;
    dmem_mode_t           cap_mode_q, cap_mode_d;
    logic                 cap_zext_q, cap_zext_d;
    logic [31:0]          cap_wd_q,   cap_wd_d;

    logic                 ld_pend_q,  ld_pend_d;
    logic                 ld_split_q, ld_split_d;
    logic [1:0]           ld_off_q,   ld_off_d;
    dmem_mode_t           ld_mode_q,  ld_mode_d;
    logic                 ld_zext_q,  ld_zext_d;
    logic [3:0][7:0]      partial_q,  partial_d;
    logic [31:0]          rd_hold_q,  rd_hold_d;

    logic [WAW-1:0]       bank_addr;
    logic [3:0]           bank_we;
    logic [3:0][7:0]      lane_wd;
    logic [3:0][7:0]      bank_rdata;
    logic [3:0]           b1_mask;
    logic [3:0][7:0]      merged;
    logic [31:0]          rd_new;
    logic                 stall;

    assign req_mode    = dmem_mode_t'(bus.AddressingControl[1:0]);
    assign req_zext    = bus.AddressingControl[2];
    assign req_off     = bus.A[1:0];
    assign req_word    = bus.A[ADDR_WIDTH-1:2];
    assign req_bytes   = mode_bytes(req_mode);
    assign req_end     = {2'b00, req_off} + {1'b0, req_bytes};
    assign req_active  = bus.req && (req_mode != MODE_NONE);
    assign req_split   = req_active && (req_end > 4'd4);
    assign unused_a_hi = ^bus.A[31:ADDR_WIDTH];

    for (genvar k = 0; k < LANES; k++) begin : g_bank
        dmem_bank #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .LANE       (k),
            .MEM_INIT   (MEM_INIT),
            .INIT_BASE  (INIT_BASE)
        ) u_bank (
            .clk   (clk),
            .we    (bank_we[k]),
            .addr  (bank_addr),
            .wdata (lane_wd[k]),
            .rdata (bank_rdata[k])
        );
    end

    always_comb begin
        state_d    = state_q;
        cap_off_d  = cap_off_q;
        cap_word_d = cap_word_q;
        cap_we_d   = cap_we_q;
        cap_mode_d = cap_mode_q;
        cap_zext_d = cap_zext_q;
        cap_wd_d   = cap_wd_q;
        ld_pend_d  = 1'b0;
        ld_split_d = ld_split_q;
        ld_off_d   = ld_off_q;
        ld_mode_d  = ld_mode_q;
        ld_zext_d  = ld_zext_q;
        partial_d  = partial_q;
        bank_addr  = req_word;
        bank_we    = 4'b0000;
        lane_wd    = rot_left(bus.WD, req_off);
        stall      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_active) begin
                    if (bus.WE) bank_we = lane_mask(req_off, req_bytes, 1'b0);
                    if (req_split) begin
                        stall      = 1'b1;
                        state_d    = S_SECOND;
                        cap_off_d  = req_off;
                        cap_word_d = req_word;
                        cap_we_d   = bus.WE;
                        cap_mode_d = req_mode;
                        cap_zext_d = req_zext;
                        cap_wd_d   = bus.WD;
                    end else if (!bus.WE) begin
                        ld_pend_d  = 1'b1;
                        ld_split_d = 1'b0;
                        ld_off_d   = req_off;
                        ld_mode_d  = req_mode;
                        ld_zext_d  = req_zext;
                    end
                end
            end
            S_SECOND: begin
                // Bank outputs now hold word w from beat 1; keep them for the merge.
                bank_addr = cap_word_q + WAW'(1);
                lane_wd   = rot_left(cap_wd_q, cap_off_q);
                if (cap_we_q) bank_we = lane_mask(cap_off_q, mode_bytes(cap_mode_q), 1'b1);
                partial_d = bank_rdata;
                state_d   = S_IDLE;
                if (!cap_we_q) begin
                    ld_pend_d  = 1'b1;
                    ld_split_d = 1'b1;
                    ld_off_d   = cap_off_q;
                    ld_mode_d  = cap_mode_q;
                    ld_zext_d  = cap_zext_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rst) begin
            stall   = 1'b0;
            bank_we = 4'b0000;
        end
    end

    always_comb begin
        b1_mask = lane_mask(ld_off_q, mode_bytes(ld_mode_q), 1'b0);
        merged  = bank_rdata;
        for (int k = 0; k < 4; k++) begin
            if (ld_split_q && b1_mask[k]) merged[k] = partial_q[k];
        end
        rd_new    = extend(rot_right(merged, ld_off_q), ld_mode_q, ld_zext_q);
        rd_hold_d = ld_pend_q ? rd_new : rd_hold_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cap_off_q  <= '0;
            cap_word_q <= '0;
            cap_we_q   <= 1'b0;
            cap_mode_q <= MODE_B;
            cap_zext_q <= 1'b0;
            cap_wd_q   <= '0;
            ld_pend_q  <= 1'b0;
            ld_split_q <= 1'b0;
            ld_off_q   <= '0;
            ld_mode_q  <= MODE_B;
            ld_zext_q  <= 1'b0;
            partial_q  <= '0;
            rd_hold_q  <= '0;
        end else begin
            state_q    <= state_d;
            cap_off_q  <= cap_off_d;
            cap_word_q <= cap_word_d;
            cap_we_q   <= cap_we_d;
            cap_mode_q <= cap_mode_d;
            cap_zext_q <= cap_zext_d;
            cap_wd_q   <= cap_wd_d;
            ld_pend_q  <= ld_pend_d;
            ld_split_q <= ld_split_d;
            ld_off_q   <= ld_off_d;
            ld_mode_q  <= ld_mode_d;
            ld_zext_q  <= ld_zext_d;
            partial_q  <= partial_d;
            rd_hold_q  <= rd_hold_d;
        end
    end

    assign bus.RD       = ld_pend_q ? rd_new : rd_hold_q;
    assign bus.rd_valid = ld_pend_q;
    assign bus.stall    = stall;

endmodule
